servo_pwm_decoder: RTL and testbench
====================================

// Module: servo_pwm_decoder
// PURPOSE
//   Receive-side counterpart of the servo PWM driver. Measures the high time of an incoming
//   servo pulse train and recovers the 8-bit position code d = round(width/2^SHIFT) - OFFSET.
//   Flags out-of-range pulses and loss of signal. Sits at a board input pin (async to clk).
// PARAMETERS
//   CTR_W        20       width of high-time counter (saturating)
//   SHIFT        8        log2 clocks per code step
//   OFFSET       165      code offset subtracted after scaling
//   TIMEOUT_CYC  2097152  cycles without a rising edge (or stuck high) before sig_lost
//   FILT_LEN     4        glitch filter stability length, used only with PWM_DEC_FILTER_EN
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   pwm_in     in   1  asynchronous servo pulse input
//   d_out      out  8  last decoded position code
//   d_valid    out  1  one-cycle strobe: d_out/range_err updated this cycle
//   range_err  out  1  last completed pulse was outside the 0..255 code range
//   sig_lost   out  1  no pulse activity for TIMEOUT_CYC cycles (sticky)
// BEHAVIOUR
//   Reset: d_out=0, d_valid=0, range_err=0, sig_lost=0, state=S_WAIT, all counters 0.
//   Sync: pwm_in -> 2-FF synchronizer (reset 0) -> pwm_s.
//   FSM:
//     S_WAIT: wait for pwm_s=0, then S_LOW (discards a pulse already in progress).
//     S_LOW : pwm_s=1 -> hi_ctr<=1, per_ctr<=0, S_HIGH.
//     S_HIGH: pwm_s=1 -> hi_ctr++ (saturates at all-ones). pwm_s=0 -> latch result, S_LOW.
//   hi_ctr therefore equals the number of cycles pwm_s was high.
//   Latency: d_valid rises on the 3rd posedge after pwm_in falls (2 sync + 1 decode).
//     d_valid is high for exactly 1 cycle.
//   Decode, CTR_W+1-bit math:
//     code = ((hi_ctr + 2^(SHIFT-1)) >> SHIFT) - OFFSET, signed.
//     code < 0              -> d_out=0,   range_err=1.
//     code > 255            -> d_out=255, range_err=1.
//     hi_ctr saturated      -> d_out=255, range_err=1.
//     otherwise             -> d_out=code, range_err=0.
//   d_out and range_err hold between strobes.
//   Watchdog: per_ctr counts every cycle and clears on each accepted rising edge.
//     At per_ctr==TIMEOUT_CYC-1: sig_lost<=1, FSM -> S_WAIT, no d_valid.
//     This also covers a line stuck high.
//     sig_lost clears on the next d_valid. per_ctr saturates and does not wrap.
//   Simultaneous: a fall and a timeout in the same cycle -> the timeout wins; the pulse is discarded.
//   rst mid-pulse: returns to S_WAIT; the remainder of that pulse yields no d_valid.
// CONFIGURATION
//   PWM_DEC_FILTER_EN defined:
//     pwm_s passes through a glitch filter.
//     The filtered level changes only after pwm_s holds the new level for FILT_LEN
//       consecutive cycles.
//     Shorter pulses/dropouts are ignored.
//     Both edges are delayed by FILT_LEN, so measured width is unchanged.
//     Latency grows by FILT_LEN cycles.
//   PWM_DEC_FILTER_EN undefined:
//     pwm_s drives the FSM directly; any high of >=1 cycle is measured.
// TESTING
//   1 width 42240 cycles, period 2^20 -> d_valid once per period, d_out=0x00, range_err=0.
//   2 width 107520 -> d_out=0xFF, range_err=0.
//   3 width 65280 -> 0x5A; 65280+100 -> 0x5A; 65280-127 -> 0x5A; 65280-129 -> 0x59; all err=0.
//   4 width 41940 -> d_out=0x00, range_err=1. width 120000 -> d_out=0xFF, range_err=1.
//   5 pwm_in held low 2^21 cycles -> sig_lost=1 at cycle TIMEOUT_CYC, no d_valid;
//     next 65280-cycle pulse -> d_valid, d_out=0x5A, sig_lost=0.
//   6 rst pulsed 1 cycle mid-pulse -> no d_valid for that pulse; next pulse decodes normally.
//     With PWM_DEC_FILTER_EN: a 2-cycle high glitch -> no d_valid.
//     Without it: the same glitch -> d_valid, d_out=0x00, range_err=1.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo pulse-width decoder: measures pulse high time, recovers the 8-bit position code, flags range errors and signal loss.
// Optional glitch filter on the synchronized input is enabled by defining PWM_DEC_FILTER_EN.
module servo_pwm_decoder #(
    parameter int CTR_W       = 20,
    parameter int SHIFT       = 8,
    parameter int OFFSET      = 165,
    parameter int TIMEOUT_CYC = 2097152,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] d_out,
    output logic       d_valid,
    output logic       range_err,
    output logic       sig_lost
);

    localparam int PER_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int PRIME_CYC = 3 + FILT_LEN;
    localparam int PR_W      = $clog2(PRIME_CYC + 1);
    localparam int FC_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [1:0] {S_WAIT, S_LOW, S_HIGH} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sync_p0;
    logic                   r_sync_p1;
    logic                   w_pwm;
    logic [PR_W-1:0]        r_prime;
    logic                   w_primed;
    logic [PER_W-1:0]       r_per_ctr;
    logic [CTR_W-1:0]       r_hi_ctr;
    logic                   w_timeout;
    logic                   w_start;
    logic                   w_latch;
    logic [8:0]             w_dec;

    // Returns {range_err, code} for a completed high time.
    function automatic logic [8:0] decode(input logic [CTR_W-1:0] hi);
        logic [CTR_W:0]          sum;
        logic signed [CTR_W+1:0] code;
        sum  = {1'b0, hi} + (CTR_W+1)'(2 ** (SHIFT - 1));
        code = $signed({1'b0, sum >> SHIFT}) - $signed((CTR_W+2)'(OFFSET));
        if (hi == {CTR_W{1'b1}})
            decode = {1'b1, 8'hFF};
        else if (code[CTR_W+1])
            decode = {1'b1, 8'h00};
        else if (code > $signed((CTR_W+2)'(255)))
            decode = {1'b1, 8'hFF};
        else
            decode = {1'b0, code[7:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= pwm_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

`ifdef PWM_DEC_FILTER_EN
    logic            r_filt;
    logic [FC_W-1:0] r_filt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt     <= 1'b0;
            r_filt_cnt <= '0;
        end else if (r_sync_p1 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FC_W'(FILT_LEN - 1)) begin
            r_filt     <= r_sync_p1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_pwm = r_filt;
`else
    assign w_pwm = r_sync_p1;
`endif

    // After reset the sync/filter pipeline still shows its reset level; hold S_WAIT
    // until it reflects the real pin so a pulse already in progress is discarded.
    always_ff @(posedge clk) begin
        if (rst)
            r_prime <= '0;
        else if (!w_primed)
            r_prime <= r_prime + 1'b1;
    end

    assign w_primed  = (r_prime == PR_W'(PRIME_CYC));
    assign w_timeout = (r_per_ctr == PER_W'(TIMEOUT_CYC - 1));
    assign w_dec     = decode(r_hi_ctr);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_WAIT: if (w_primed && !w_pwm) w_state_nxt = S_LOW;
            S_LOW: begin
                if (w_pwm) begin
                    w_state_nxt = S_HIGH;
                    w_start     = 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_pwm) begin
                    w_state_nxt = S_LOW;
                    w_latch     = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase
        // Watchdog overrides everything, including a coincident falling edge.
        if (w_timeout) begin
            w_state_nxt = S_WAIT;
            w_start     = 1'b0;
            w_latch     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_WAIT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_ctr <= '0;
            r_hi_ctr  <= '0;
        end else begin
            if (w_start)
                r_per_ctr <= '0;
            else if (r_per_ctr != PER_W'(TIMEOUT_CYC))
                r_per_ctr <= r_per_ctr + 1'b1;

            if (w_start)
                r_hi_ctr <= CTR_W'(1);
            else if (r_state == S_HIGH && w_pwm && r_hi_ctr != {CTR_W{1'b1}})
                r_hi_ctr <= r_hi_ctr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out     <= 8'h00;
            d_valid   <= 1'b0;
            range_err <= 1'b0;
            sig_lost  <= 1'b0;
        end else begin
            d_valid <= w_latch;
            if (w_latch) begin
                d_out     <= w_dec[7:0];
                range_err <= w_dec[8];
                sig_lost  <= 1'b0;
            end
            if (w_timeout)
                sig_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with scaled parameters (SHIFT=2, OFFSET=3, CTR_W=11, TIMEOUT_CYC=3000).
// Code mapping: d = ((w + 2) >> 2) - 3, so width 4*(d+3) decodes to d.
module tb_servo_pwm_decoder;

    localparam int CTR_W   = 11;
    localparam int SHIFT   = 2;
    localparam int OFFSET  = 3;
    localparam int TIMEOUT = 3000;
    localparam int FILT    = 4;
`ifdef PWM_DEC_FILTER_EN
    localparam int FL = FILT;
`else
    localparam int FL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [7:0] d_out;
    logic       d_valid;
    logic       range_err;
    logic       sig_lost;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         dv_cnt = 0;
    int         t_rise = 0;
    logic [7:0] cap_d = 8'h00;
    logic       cap_err = 1'b0;
    logic       cap_lost = 1'b0;

    servo_pwm_decoder #(
        .CTR_W(CTR_W), .SHIFT(SHIFT), .OFFSET(OFFSET), .TIMEOUT_CYC(TIMEOUT), .FILT_LEN(FILT)
    ) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .d_out(d_out),
        .d_valid(d_valid), .range_err(range_err), .sig_lost(sig_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (d_valid) begin
            dv_cnt++;
            cap_d    = d_out;
            cap_err  = range_err;
            cap_lost = sig_lost;
        end
    endtask

    task automatic pulse(input string tag, input int w, input int ed, input int ee);
        int c0;
        int lat;
        tick();
        c0     = dv_cnt;
        pwm_in = 1'b1;
        t_rise = cyc;
        repeat (w) tick();
        pwm_in = 1'b0;
        lat    = 0;
        while (dv_cnt == c0 && lat < 64) begin
            tick();
            lat++;
        end
        repeat (20) tick();
        chk({tag, "_lat"}, lat, 3 + FL);
        chk({tag, "_cnt"}, dv_cnt - c0, 1);
        chk({tag, "_d"}, int'(cap_d), ed);
        chk({tag, "_err"}, int'(cap_err), ee);
        chk({tag, "_lost"}, int'(cap_lost), 0);
    endtask

    initial begin
        int c0;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) tick();
        chk("rst_d", int'(d_out), 0);
        chk("rst_dv", int'(d_valid), 0);
        chk("rst_err", int'(range_err), 0);
        chk("rst_lost", int'(sig_lost), 0);
        rst = 1'b0;
        repeat (20) tick();

        // In-range codes and the rounding boundary around 0x5A.
        pulse("min", 12, 8'h00, 0);
        pulse("max", 1032, 8'hFF, 0);
        pulse("mid", 372, 8'h5A, 0);
        pulse("mid_p1", 373, 8'h5A, 0);
        pulse("mid_m2", 370, 8'h5A, 0);
        pulse("mid_m3", 369, 8'h59, 0);
        pulse("lo_edge", 10, 8'h00, 0);
        pulse("max_edge", 1033, 8'hFF, 0);

        // Out-of-range widths, including counter saturation.
        pulse("under", 9, 8'h00, 1);
        pulse("over", 1034, 8'hFF, 1);
        pulse("sat", 2100, 8'hFF, 1);

        // Line held low: sig_lost exactly TIMEOUT cycles after the accepted rise.
        c0 = dv_cnt;
        while (!sig_lost && (cyc - t_rise) < 5000) tick();
        chk("tmo_cyc", cyc - t_rise, TIMEOUT + 3 + FL);
        chk("tmo_lost", int'(sig_lost), 1);
        chk("tmo_nodv", dv_cnt - c0, 0);
        pulse("recover", 372, 8'h5A, 0);
        chk("recover_lost", int'(sig_lost), 0);

        // Line stuck high: timeout while high, no strobe on the late fall.
        tick();
        c0     = dv_cnt;
        pwm_in = 1'b1;
        t_rise = cyc;
        while (!sig_lost && (cyc - t_rise) < 5000) tick();
        chk("stuck_cyc", cyc - t_rise, TIMEOUT + 3 + FL);
        repeat (100) tick();
        pwm_in = 1'b0;
        repeat (40) tick();
        chk("stuck_nodv", dv_cnt - c0, 0);
        chk("stuck_lost", int'(sig_lost), 1);
        pulse("after_stuck", 400, 8'h61, 0);

        // Reset in the middle of a pulse.
        tick();
        c0     = dv_cnt;
        pwm_in = 1'b1;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_d", int'(d_out), 0);
        chk("midrst_err", int'(range_err), 0);
        repeat (50) tick();
        pwm_in = 1'b0;
        repeat (40) tick();
        chk("midrst_nodv", dv_cnt - c0, 0);
        pulse("post_rst", 300, 8'h48, 0);

        // Two-cycle glitch.
`ifdef PWM_DEC_FILTER_EN
        tick();
        c0     = dv_cnt;
        pwm_in = 1'b1;
        repeat (2) tick();
        pwm_in = 1'b0;
        repeat (40) tick();
        chk("glitch_nodv", dv_cnt - c0, 0);
`else
        pulse("glitch", 2, 8'h00, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
